// File: rtl/cover_sched_pkg.sv
// Shared widths and helpers for the toggle-coverage report scheduler.
package cover_sched_pkg;

  localparam int unsigned COVER_IDX_W = 64;

  // Width needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [COVER_IDX_W-1:0] make_index(
    input logic [COVER_IDX_W-1:0] base,
    input logic [31:0]            off
  );
    return base + COVER_IDX_W'(off);
  endfunction

endpackage

// File: rtl/cover_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module cover_rr_pick #(
  parameter int unsigned W     = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic [W-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             any_o,
  output logic [W-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o
);

  localparam int unsigned DW = 2 * W;

  logic [DW-1:0] dbl;
  logic [DW-1:0] mask;
  logic          found;

  // Upper copy of the request vector supplies the wrapped candidates.
  always_comb begin
    dbl     = {req_i, req_i};
    mask    = ~((DW'(1) << ptr_i) - DW'(1));
    found   = 1'b0;
    idx_o   = '0;
    for (int unsigned j = 0; j < DW; j++) begin
      if (!found && dbl[j] && mask[j]) begin
        found = 1'b1;
        idx_o = PTR_W'(j % W);
      end
    end
    any_o   = |req_i;
    grant_o = found ? (W'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// Deduplicating scheduler: serialises first-time toggle-coverage hits into a
// single valid/ready stream, one global cover index per handshake.
module cover_toggle_sched
  import cover_sched_pkg::*;
#(
  parameter int unsigned COVER_WIDTH = 16,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned CNT_W       = cnt_width(COVER_WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [COVER_WIDTH-1:0] valid,
  input  logic                   rearm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic [CNT_W-1:0]       covered_count,
  output logic                   busy
);

  localparam int unsigned PTR_W = $clog2(COVER_WIDTH);

  logic [COVER_WIDTH-1:0] pending_q, pending_d;
  logic [COVER_WIDTH-1:0] covered_q, covered_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [COVER_IDX_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   pick_any;
  logic [COVER_WIDTH-1:0] pick_grant;
  logic [PTR_W-1:0]       pick_idx;
  logic                   slot_free;
  logic                   load;
  logic [COVER_WIDTH-1:0] loaded_bit;

  cover_rr_pick #(
    .W     (COVER_WIDTH),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .any_o   (pick_any),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Capture, load and rearm bookkeeping.
  always_comb begin
    pending_d   = pending_q;
    covered_d   = covered_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    count_d     = count_q;

    slot_free  = !out_valid_q || out_ready;
    load       = slot_free && !rearm && pick_any;
    loaded_bit = load ? pick_grant : '0;

    if (rearm) begin
      pending_d = '0;
      covered_d = '0;
      count_d   = '0;
    end else begin
      pending_d = pending_q & ~loaded_bit;
      if (en) begin
        pending_d = pending_d | (valid & ~covered_q & ~loaded_bit);
      end
      covered_d = covered_q | loaded_bit;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_index_d = make_index(COVER_IDX_W'(COVER_INDEX), 32'(pick_idx));
      ptr_d       = (pick_idx == PTR_W'(COVER_WIDTH - 1)) ? '0 : pick_idx + PTR_W'(1);
      if (count_q < CNT_W'(COVER_WIDTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= '0;
      covered_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      count_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      covered_q   <= covered_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      count_q     <= count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_index     = out_index_q;
  assign covered_count = count_q;
  assign busy          = out_valid_q || (|pending_q);

endmodule

// File: doc/cover_toggle_sched.md
Name: cover_toggle_sched

Overview:
- Deduplicating scheduler for toggle-coverage hits.
- Samples a flat vector of per-bit toggle events and remembers which cover points have already been reported.
- Serialises each first-time hit into a single valid/ready report stream, one cover index per handshake.
- Sits between the per-signal toggle sampling groups and the single coverage reporting sink, so the sink sees each point once per arm epoch instead of every cycle.

Parameters:
- COVER_WIDTH, 16, number of cover points (bits of valid) handled by this instance; minimum 2.
- COVER_INDEX, 0, global index of bit 0; bit i reports COVER_INDEX+i.
- CNT_W, $clog2(COVER_WIDTH+1), width of covered_count.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  capture enable; when 0, no new hits are captured, but draining continues.
- valid  in  COVER_WIDTH  per-point toggle hit, sampled each cycle.
- rearm  in  1  one-cycle pulse; forgets covered and pending state.
- out_valid  out  1  report slot holds an index.
- out_ready  in  1  sink accepts the report.
- out_index  out  64  global cover index, COVER_INDEX + i, zero-extended to 64 bits.
- covered_count  out  CNT_W  distinct points issued since reset or rearm.
- busy  out  1  out_valid OR any pending bit.

Behaviour:
- State:
  - pending[COVER_WIDTH]
  - covered[COVER_WIDTH] (set = issued)
  - ptr (round-robin start, 0..COVER_WIDTH-1)
  - out_valid/out_index output slot
  - covered_count
- Reset: pending=0, covered=0, ptr=0, out_valid=0, out_index=0, covered_count=0.
  - Reset mid-operation drops any in-flight report and all pending hits.
- Capture (en=1, rearm=0): pending <= (pending & ~loaded_bit) | (valid & ~covered & ~loaded_bit).
  - A hit on a covered or already-pending bit is dropped; it is never queued twice.
- Slot free = !out_valid | out_ready.
- Load, when slot free, rearm=0 and pending≠0:
  - Pick the first pending bit at or after ptr, wrapping modulo COVER_WIDTH.
  - out_index <= COVER_INDEX+i; out_valid <= 1.
  - Clear pending[i]; set covered[i]; ptr <= (i+1) mod COVER_WIDTH.
  - covered_count increments, saturating at COVER_WIDTH.
- Slot free and nothing pending: out_valid <= 0.
- Hold: while out_valid=1 and out_ready=0, out_index stays stable and no load occurs.
- Throughput: one report per cycle under continuous out_ready=1.
- Latency: hit sampled at edge k → pending after edge k → out_valid high after edge k+1, provided the slot is free and no earlier-priority pending bit exists.
- A hit arriving on the same bit being loaded that cycle is dropped.
- rearm=1:
  - At the next edge, pending, covered and covered_count are cleared; ptr is unchanged.
  - Capture and load are suppressed that cycle; hits in that cycle are lost.
  - An occupied slot is not cancelled: it keeps out_valid/out_index until accepted.
- busy is combinational from registered state.

Decomposition:
- Package cover_sched_pkg:
  - COVER_IDX_W=64.
  - Function computing the clog2-based width.
  - Function forming the 64-bit index from base plus offset.
- Sub-module cover_rr_pick: combinational round-robin picker.
  - Inputs: request vector, ptr.
  - Outputs: any, one-hot grant, binary index.
  - Implemented by double-width masking of the request vector.

Test Plan:
(All scenarios use COVER_WIDTH=8, COVER_INDEX=100.)
- Single hit: reset, valid=0x04 for 1 cycle, out_ready=1 → out_valid high for exactly 1 cycle, 2 edges after the hit, with out_index=102; covered_count=1. Repeat valid=0x04 → no report; count stays 1.
- Burst: after reset, valid=0xFF for 1 cycle, out_ready=1 → indices 100..107 on 8 consecutive cycles; covered_count=8; busy then 0.
- Backpressure: after reset, valid=0x03, out_ready=0 for 5 cycles → out_index=100 held stable with out_valid=1; then out_ready=1 → 100 accepted, then 101 follows on the next cycle.
- Wrap: issue bit 5 (ptr=6), then valid=0x82 → reports 107 then 101, in that order.
- Rearm: all 8 points covered; rearm=1 with valid=0x01 in the same cycle → count=0 and no report. Next cycle valid=0x01 → report 100; count=1.
- Reset mid-operation: with pending=0x30 and out_valid=1, assert reset 1 cycle → out_valid=0, busy=0, count=0. Then valid=0x10 → report 104.
